// File: rtl/pc_gen.sv
// Fetch-stage program counter: issues the fetch PC over a valid/ready handshake,
// steps sequentially by one fetch group, and buffers redirects that arrive while a request is unaccepted.
module pc_gen #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h1c000000),
  parameter int unsigned      INST_BYTES   = 4,
  parameter int unsigned      FETCH_WIDTH  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_target,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_adef,
  output logic            redir_pending
);

  localparam int unsigned     ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [XLEN-1:0] STEP       = XLEN'(FETCH_WIDTH * INST_BYTES);

  // Handshake: a request is offered while fetch_valid is high; fetch_pc and
  // fetch_valid stay stable until fetch_valid & fetch_ready is seen at a clock edge.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    PEND = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [XLEN-1:0]   pend_tgt, pend_tgt_n;
  logic              pend_exc, pend_exc_n;

  logic              fire;
  logic              redir;
  logic [XLEN-1:0]   redir_tgt;
  logic              take_new;
  logic [XLEN-1:0]   merged_tgt;

  assign fetch_valid   = (state == REQ) || (state == PEND);
  assign redir_pending = (state == PEND);
  assign fetch_pc      = pc;
  assign fetch_adef    = fetch_valid && (pc[ALIGN_BITS-1:0] != '0);

  assign fire      = fetch_valid && fetch_ready;
  assign redir     = exc_valid || br_valid;
  assign redir_tgt = exc_valid ? exc_target : br_target;

  // A buffered exception is never displaced by a later branch.
  assign take_new   = exc_valid || (br_valid && !pend_exc);
  assign merged_tgt = take_new ? redir_tgt : pend_tgt;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_tgt_n = pend_tgt;
    pend_exc_n = pend_exc;
    case (state)
      BOOT: state_n = IDLE;
      IDLE: begin
        if (redir)       pc_n    = redir_tgt;
        else if (!stall) state_n = REQ;
      end
      REQ: begin
        if (fire) begin
          pc_n    = redir ? redir_tgt : pc + STEP;
          state_n = stall ? IDLE : REQ;
        end else if (redir) begin
          pend_tgt_n = redir_tgt;
          pend_exc_n = exc_valid;
          state_n    = PEND;
        end
      end
      PEND: begin
        if (fire) begin
          pc_n       = merged_tgt;
          pend_tgt_n = '0;
          pend_exc_n = 1'b0;
          state_n    = stall ? IDLE : REQ;
        end else begin
          pend_tgt_n = merged_tgt;
          pend_exc_n = pend_exc || exc_valid;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pend_tgt <= '0;
      pend_exc <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend_tgt <= pend_tgt_n;
      pend_exc <= pend_exc_n;
    end
  end

endmodule
